// File: rtl/sub_result_arbiter.sv
// Round-robin arbiter that shares one registered result channel among NUM_REQ
// requesters, holding the grant on one requester for up to MAX_BURST beats.
module sub_result_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 4,
   parameter int TAG_W     = 3,
   parameter int MAX_BURST = 8,
   localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_last,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [TAG_W-1:0]           out_tag,
   output logic [SRC_W-1:0]           out_src,
   output logic                       out_last
);

   // state   | meaning
   // ST_ARB  | grant re-evaluated each cycle, round-robin from r_ptr
   // ST_LOCK | grant pinned to r_owner until last beat or MAX_BURST beats
   localparam logic [0:0] ST_ARB  = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   logic [0:0]          r_state;
   logic [SRC_W-1:0]    r_ptr;
   logic [SRC_W-1:0]    r_owner;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic [TAG_W-1:0]    r_out_tag;
   logic [SRC_W-1:0]    r_out_src;
   logic                r_out_last;

   logic                w_can_load;
   logic [SRC_W-1:0]    w_sel;
   logic                w_found;
   logic [SRC_W-1:0]    w_cand;
   logic [NUM_REQ-1:0]  w_ready;
   logic                w_xfer;
   logic [DATA_W-1:0]   w_data;
   logic [TAG_W-1:0]    w_tag;
   logic                w_last;

   function automatic logic [SRC_W-1:0] f_next(input logic [SRC_W-1:0] x);
      return (x == SRC_W'(NUM_REQ - 1)) ? '0 : x + SRC_W'(1);
   endfunction

   assign w_can_load = !r_out_valid || out_ready;

   // Descending scan so the candidate closest to r_ptr is written last and wins.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      if (r_state == ST_LOCK) begin
         w_sel   = r_owner;
         w_found = req_valid[r_owner];
      end else begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = SRC_W'((int'(r_ptr) + k) % NUM_REQ);
            if (req_valid[w_cand]) begin
               w_sel   = w_cand;
               w_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_ready = '0;
      w_data  = '0;
      w_tag   = '0;
      w_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel == SRC_W'(i)) begin
            w_ready[i] = !rst && w_can_load && w_found;
            w_data     = req_data[i*DATA_W +: DATA_W];
            w_tag      = req_tag[i*TAG_W +: TAG_W];
            w_last     = req_last[i];
         end
      end
   end

   assign w_xfer = |w_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_ARB;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_tag   <= '0;
         r_out_src   <= '0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_can_load) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
               r_out_data <= w_data;
               r_out_tag  <= w_tag;
               r_out_src  <= w_sel;
               r_out_last <= w_last;
            end
         end
         if (w_xfer) begin
            if (r_state == ST_ARB) begin
               if (w_last) begin
                  r_ptr <= f_next(w_sel);
               end else begin
                  r_owner <= w_sel;
                  r_cnt   <= CNT_W'(1);
                  r_state <= ST_LOCK;
               end
            end else if (w_last || (r_cnt == CNT_W'(MAX_BURST - 1))) begin
               // Forced release at MAX_BURST: owner's remaining beats re-arbitrate.
               r_ptr   <= f_next(r_owner);
               r_cnt   <= '0;
               r_state <= ST_ARB;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign req_ready = w_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_tag   = r_out_tag;
   assign out_src   = r_out_src;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_sub_result_arbiter.sv
// Table-driven bench for sub_result_arbiter: per-cycle vectors give inputs and
// the expected grant; accepted beats are queued and checked at the output.
module tb_sub_result_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [15:0] req_data;
   logic [11:0] req_tag;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic [2:0]  out_tag;
   logic [1:0]  out_src;
   logic        out_last;

   always #5 clk = ~clk;

   sub_result_arbiter #(.NUM_REQ(4), .DATA_W(4), .TAG_W(3), .MAX_BURST(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .out_src(out_src), .out_last(out_last)
   );

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic [3:0] last;
      logic       ordy;
      logic [3:0] exp_ready;
   } vec_t;

   typedef struct {
      logic [3:0] data;
      logic [2:0] tag;
      logic [1:0] src;
      logic       last;
   } beat_t;

   vec_t  vecs[$];
   beat_t sb[$];
   logic [3:0] d[4];
   logic [2:0] t[4];
   logic       exp_ov;
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic o, input logic [3:0] e);
      vec_t x;
      x.rst = r; x.valid = v; x.last = l; x.ordy = o; x.exp_ready = e;
      vecs.push_back(x);
   endtask

   task automatic apply(input vec_t v);
      rst       = v.rst;
      req_valid = v.valid;
      req_last  = v.last;
      out_ready = v.ordy;
      for (int i = 0; i < 4; i++) begin
         req_data[i*4 +: 4] = d[i];
         req_tag[i*3 +: 3]  = t[i];
      end
   endtask

   initial begin
      d[0] = 4'h3; d[1] = 4'h7; d[2] = 4'hA; d[3] = 4'hC;
      t[0] = 3'd1; t[1] = 3'd2; t[2] = 3'd5; t[3] = 3'd6;

      // bring-up: req 2 alone, single beat
      add(0, 4'b0100, 4'b0100, 1, 4'b0100);
      add(0, 4'b0000, 4'b0000, 1, 4'b0000);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000);
      // all valid single-beat: 0,1,2,3,0
      add(0, 4'b1111, 4'b1111, 1, 4'b0001);
      add(0, 4'b1111, 4'b1111, 1, 4'b0010);
      add(0, 4'b1111, 4'b1111, 1, 4'b0100);
      add(0, 4'b1111, 4'b1111, 1, 4'b1000);
      add(0, 4'b1111, 4'b1111, 1, 4'b0001);
      // 3-beat burst from req 1 with 0 and 3 waiting
      add(0, 4'b1011, 4'b1001, 1, 4'b0010);
      add(0, 4'b1011, 4'b1001, 1, 4'b0010);
      add(0, 4'b1011, 4'b1011, 1, 4'b0010);
      add(0, 4'b1001, 4'b1001, 1, 4'b1000);
      add(0, 4'b0001, 4'b0001, 1, 4'b0001);
      // req 0 never asserts last: forced release after 8 beats
      add(0, 4'b0001, 4'b0000, 1, 4'b0001);
      for (int k = 0; k < 7; k++) add(0, 4'b0011, 4'b0010, 1, 4'b0001);
      add(0, 4'b0011, 4'b0010, 1, 4'b0010);
      add(0, 4'b0001, 4'b0000, 1, 4'b0001);
      add(0, 4'b0001, 4'b0001, 1, 4'b0001);
      // stall for 5 cycles, then reload on the cycle out_ready rises
      add(0, 4'b0100, 4'b0100, 1, 4'b0100);
      for (int k = 0; k < 5; k++) add(0, 4'b0001, 4'b0001, 0, 4'b0000);
      add(0, 4'b0001, 4'b0001, 1, 4'b0001);
      add(0, 4'b0000, 4'b0000, 1, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 4'b0000);
      // reset during beat 2 of a locked burst from req 3
      add(0, 4'b1000, 4'b0000, 1, 4'b1000);
      add(1, 4'b1000, 4'b0000, 1, 4'b0000);
      add(0, 4'b1001, 4'b1001, 1, 4'b0001);
      add(0, 4'b1000, 4'b1000, 1, 4'b1000);
      add(0, 4'b0000, 4'b0000, 1, 4'b0000);
      // owner drops valid mid-burst: channel idles, others wait
      add(0, 4'b0010, 4'b0000, 1, 4'b0010);
      add(0, 4'b0101, 4'b0101, 1, 4'b0000);
      add(0, 4'b0111, 4'b0111, 1, 4'b0010);
      add(0, 4'b0101, 4'b0101, 1, 4'b0100);
      add(0, 4'b0001, 4'b0001, 1, 4'b0001);
      // lone requester granted back-to-back
      for (int k = 0; k < 3; k++) add(0, 4'b0100, 4'b0100, 1, 4'b0100);
      add(0, 4'b0000, 4'b0000, 1, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 4'b0000);

      // reset with req 2 already valid
      begin
         vec_t r0;
         r0.rst = 1; r0.valid = 4'b0100; r0.last = 4'b0100; r0.ordy = 1; r0.exp_ready = 4'b0000;
         apply(r0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_ov",    32'(out_valid), 32'h0);
      chk("rst_data",  32'(out_data),  32'h0);
      chk("rst_tag",   32'(out_tag),   32'h0);
      chk("rst_src",   32'(out_src),   32'h0);
      chk("rst_last",  32'(out_last),  32'h0);
      exp_ov = 1'b0;

      foreach (vecs[n]) begin
         vec_t v;
         int   g;
         logic can;
         v = vecs[n];
         @(posedge clk);
         #1;
         apply(v);
         @(negedge clk);
         chk($sformatf("ready[%0d]", n), 32'(req_ready), 32'(v.exp_ready));
         chk($sformatf("ov[%0d]", n), 32'(out_valid), 32'(exp_ov));
         if (exp_ov) begin
            if (sb.size() == 0) begin
               chk($sformatf("sb_empty[%0d]", n), 32'(sb.size()), 32'd1);
            end else begin
               chk($sformatf("data[%0d]", n), 32'(out_data), 32'(sb[0].data));
               chk($sformatf("tag[%0d]",  n), 32'(out_tag),  32'(sb[0].tag));
               chk($sformatf("src[%0d]",  n), 32'(out_src),  32'(sb[0].src));
               chk($sformatf("last[%0d]", n), 32'(out_last), 32'(sb[0].last));
            end
         end
         g = -1;
         for (int i = 0; i < 4; i++) if (v.exp_ready[i]) g = i;
         if (v.rst) begin
            exp_ov = 1'b0;
            sb.delete();
         end else begin
            can = !exp_ov || v.ordy;
            if (exp_ov && v.ordy && sb.size() > 0) void'(sb.pop_front());
            if (can) begin
               exp_ov = (g >= 0);
               if (g >= 0) begin
                  beat_t b;
                  b.data = d[g]; b.tag = t[g]; b.src = 2'(g); b.last = v.last[g];
                  sb.push_back(b);
               end
            end
            if (g >= 0) begin
               d[g] = d[g] + 4'd5;
               t[g] = t[g] + 3'd3;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
